// File: rtl/memory_access_unit_pkg.sv
// Shared types for the memory access unit: command encoding, FSM state and
// the address-datapath command.
package control;

    localparam int ADDR_BUS_WIDTH = 9;

    typedef enum logic [2:0] {
        MEM_NOP      = 3'd0,
        MEM_ABSOLUTE = 3'd1,
        MEM_REL_ADD  = 3'd2,
        MEM_REL_SUB  = 3'd3,
        MEM_READ     = 3'd4,
        MEM_WRITE    = 3'd5
    } memory_op_e;

    typedef enum logic [0:0] {MAU_IDLE, MAU_BUS} mau_state_e;

    typedef enum logic [1:0] {ADDR_HOLD, ADDR_LOAD, ADDR_ADD, ADDR_SUB} addr_cmd_e;

endpackage

// File: rtl/mem_addr_gen.sv
// Address register with load/add/subtract datapath; wrap is a registered
// one-cycle pulse on carry-out (add) or borrow (subtract).
module mem_addr_gen
    import control::*;
#(
    parameter int ADDR_WIDTH = ADDR_BUS_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  addr_cmd_e             cmd,
    input  logic [ADDR_WIDTH-1:0] operand,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wrap
);

    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  wrap_reg, wrap_next;
    logic [ADDR_WIDTH:0]   sum_ext, diff_ext;

    // Extra top bit captures carry-out of the add and borrow of the subtract.
    assign sum_ext  = {1'b0, addr_reg} + {1'b0, operand};
    assign diff_ext = {1'b0, addr_reg} - {1'b0, operand};

    always_comb begin
        addr_next = addr_reg;
        wrap_next = 1'b0;
        case (cmd)
            ADDR_LOAD: addr_next = operand;
            ADDR_ADD: begin
                addr_next = sum_ext[ADDR_WIDTH-1:0];
                wrap_next = sum_ext[ADDR_WIDTH];
            end
            ADDR_SUB: begin
                addr_next = diff_ext[ADDR_WIDTH-1:0];
                wrap_next = diff_ext[ADDR_WIDTH];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg <= '0;
            wrap_reg <= 1'b0;
        end else begin
            addr_reg <= addr_next;
            wrap_reg <= wrap_next;
        end
    end

    assign addr = addr_reg;
    assign wrap = wrap_reg;

endmodule

// File: rtl/memory_access_unit.sv
// Executes memory_op_e commands against a req/ack RAM and owns the address
// register. Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
module memory_access_unit
    import control::*;
#(
    parameter int ADDR_WIDTH     = ADDR_BUS_WIDTH,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  memory_op_e            op_i,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    input  logic                  post_inc_i,
    input  logic [ADDR_WIDTH-1:0] addr_operand_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_wrap_o,
    output logic                  err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    mau_state_e            state_reg;
    logic                  req_reg, we_reg, post_inc_reg, rdata_valid_reg, err_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg, rdata_reg;
    addr_cmd_e             addr_cmd;
    logic [ADDR_WIDTH-1:0] addr_opd;
    logic                  accept, is_mem_op;

    assign op_ready_o = (state_reg == MAU_IDLE);
    assign accept     = op_valid_i && op_ready_o;
    assign is_mem_op  = (op_i == MEM_READ) || (op_i == MEM_WRITE);

    always_comb begin
        addr_cmd = ADDR_HOLD;
        addr_opd = addr_operand_i;
        if (accept) begin
            case (op_i)
                MEM_ABSOLUTE: addr_cmd = ADDR_LOAD;
                MEM_REL_ADD:  addr_cmd = ADDR_ADD;
                MEM_REL_SUB:  addr_cmd = ADDR_SUB;
                default:      addr_cmd = ADDR_HOLD;
            endcase
        end else if (state_reg == MAU_BUS && mem_ack_i && post_inc_reg) begin
            addr_cmd = ADDR_ADD;
            addr_opd = ADDR_WIDTH'(1);
        end
    end

    mem_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd     (addr_cmd),
        .operand (addr_opd),
        .addr    (addr_o),
        .wrap    (addr_wrap_o)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             expired;

    // Expiry is the TIMEOUT_CYCLES-th BUS cycle that ends without ack.
    assign expired = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= MAU_IDLE;
            req_reg         <= 1'b0;
            we_reg          <= 1'b0;
            post_inc_reg    <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            rdata_reg       <= '0;
            rdata_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_reg    <= '0;
`endif
        end else begin
            rdata_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
            case (state_reg)
                MAU_IDLE: begin
                    if (accept && is_mem_op) begin
                        state_reg     <= MAU_BUS;
                        req_reg       <= 1'b1;
                        we_reg        <= (op_i == MEM_WRITE);
                        post_inc_reg  <= post_inc_i;
                        mem_addr_reg  <= addr_o;
                        mem_wdata_reg <= wdata_i;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt_reg  <= '0;
`endif
                    end
                end
                default: begin
                    if (mem_ack_i) begin
                        state_reg <= MAU_IDLE;
                        req_reg   <= 1'b0;
                        if (!we_reg) begin
                            rdata_reg       <= mem_rdata_i;
                            rdata_valid_reg <= 1'b1;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (expired) begin
                        state_reg <= MAU_IDLE;
                        req_reg   <= 1'b0;
                        err_reg   <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif
    assign mem_req_o     = req_reg;
    assign mem_we_o      = we_reg;
    assign mem_addr_o    = mem_addr_reg;
    assign mem_wdata_o   = mem_wdata_reg;
    assign rdata_o       = rdata_reg;
    assign rdata_valid_o = rdata_valid_reg;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed plus randomized bench for memory_access_unit against an
// arithmetic reference model of the address register and read data.
module tb_memory_access_unit;
    import control::*;

    localparam int AW = 9;
    localparam int DW = 8;
    localparam int TO = 4;
    localparam int AMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    memory_op_e    op_i;
    logic          op_valid_i, op_ready_o, post_inc_i;
    logic [AW-1:0] addr_operand_i, addr_o, mem_addr_o;
    logic [DW-1:0] wdata_i, rdata_o, mem_wdata_o, mem_rdata_i;
    logic          rdata_valid_o, addr_wrap_o, err_o;
    logic          mem_req_o, mem_we_o, mem_ack_i;

    int n_cmp = 0;
    int n_err = 0;

    int m_addr;
    int m_rdata;

    always #5 clk = ~clk;

    memory_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .op_i           (op_i),
        .op_valid_i     (op_valid_i),
        .op_ready_o     (op_ready_o),
        .post_inc_i     (post_inc_i),
        .addr_operand_i (addr_operand_i),
        .wdata_i        (wdata_i),
        .rdata_o        (rdata_o),
        .rdata_valid_o  (rdata_valid_o),
        .addr_o         (addr_o),
        .addr_wrap_o    (addr_wrap_o),
        .err_o          (err_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .mem_ack_i      (mem_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_idle_inputs();
        op_i           = memory_op_e'(3'($urandom_range(0, 7)));
        addr_operand_i = AW'($urandom);
        post_inc_i     = 1'($urandom);
        wdata_i        = DW'($urandom);
    endtask

    // One complete command; waits = number of req cycles before the ack cycle.
    task automatic do_op(input memory_op_e op, input int opd, input bit pinc,
                         input int wd, input int waits, input int rd);
        int  exp_addr;
        bit  exp_wrap;
        bit  is_mem;
        bit  is_wr;
        @(negedge clk);
        chk("ready_idle", op_ready_o, 1);
        chk("wrap_quiet", addr_wrap_o, 0);
        chk("rvalid_quiet", rdata_valid_o, 0);
        op_i = op; op_valid_i = 1'b1; addr_operand_i = AW'(opd);
        post_inc_i = pinc; wdata_i = DW'(wd); mem_ack_i = 1'b0;
        is_wr  = (op == MEM_WRITE);
        is_mem = (op == MEM_READ) || is_wr;
        exp_addr = m_addr;
        exp_wrap = 1'b0;
        case (op)
            MEM_ABSOLUTE: exp_addr = opd;
            MEM_REL_ADD: begin
                exp_wrap = (m_addr + opd) >= AMOD;
                exp_addr = (m_addr + opd) % AMOD;
            end
            MEM_REL_SUB: begin
                exp_wrap = opd > m_addr;
                exp_addr = (m_addr - opd + AMOD) % AMOD;
            end
            default: ;
        endcase
        @(posedge clk);
        @(negedge clk);
        op_valid_i = 1'b0;
        scramble_idle_inputs();
        if (!is_mem) begin
            m_addr = exp_addr;
            chk("addr_op_addr", addr_o, m_addr);
            chk("addr_op_wrap", addr_wrap_o, exp_wrap);
            chk("addr_op_ready", op_ready_o, 1);
            chk("addr_op_noreq", mem_req_o, 0);
        end else begin
            for (int i = 0; i <= waits; i++) begin
                if (i > 0) @(negedge clk);
                chk("bus_req", mem_req_o, 1);
                chk("bus_we", mem_we_o, is_wr);
                chk("bus_addr", mem_addr_o, m_addr);
                chk("bus_busy", op_ready_o, 0);
                chk("bus_rvalid", rdata_valid_o, 0);
                chk("bus_err", err_o, 0);
                chk("bus_addr_hold", addr_o, m_addr);
                if (is_wr) chk("bus_wdata", mem_wdata_o, wd);
                if (i == waits) begin
                    mem_ack_i = 1'b1; mem_rdata_i = DW'(rd); op_valid_i = 1'b0;
                end else begin
                    mem_ack_i = 1'b0; mem_rdata_i = DW'($urandom);
                    op_valid_i = 1'b1;
                    scramble_idle_inputs();
                end
                @(posedge clk);
            end
            @(negedge clk);
            mem_ack_i = 1'b0; op_valid_i = 1'b0;
            if (!is_wr) m_rdata = rd;
            if (pinc) begin
                exp_wrap = (m_addr == AMOD - 1);
                m_addr   = (m_addr + 1) % AMOD;
            end
            chk("done_noreq", mem_req_o, 0);
            chk("done_ready", op_ready_o, 1);
            chk("done_rvalid", rdata_valid_o, !is_wr);
            chk("done_rdata", rdata_o, m_rdata);
            chk("done_addr", addr_o, m_addr);
            chk("done_wrap", addr_wrap_o, exp_wrap);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; op_valid_i = 1'b0; op_i = MEM_NOP; post_inc_i = 1'b0;
        addr_operand_i = '0; wdata_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
        m_addr = 0; m_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", op_ready_o, 1);
        chk("rst_addr", addr_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_maddr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_err", err_o, 0);

        do_op(MEM_ABSOLUTE, 'h1F0, 0, 0, 0, 0);
        do_op(MEM_REL_ADD,  'h020, 0, 0, 0, 0);
        chk("dir_add_wrap_addr", addr_o, 'h010);
        do_op(MEM_REL_SUB,  'h020, 0, 0, 0, 0);
        chk("dir_sub_wrap_addr", addr_o, 'h1F0);
        do_op(MEM_ABSOLUTE, 'h1FF, 0, 0, 0, 0);
        do_op(MEM_READ,     0,     1, 0, 0, 'hA5);
        chk("dir_read_data", rdata_o, 'hA5);
        chk("dir_read_inc", addr_o, 0);
        do_op(MEM_WRITE,    0,     0, 'h3C, 3, 0);
        do_op(memory_op_e'(3'd7), 'h055, 1, 0, 0, 0);

`ifdef MEM_TIMEOUT_EN
        @(negedge clk);
        op_i = MEM_READ; op_valid_i = 1'b1; post_inc_i = 1'b1; mem_ack_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op_valid_i = 1'b0;
        for (int i = 0; i < TO; i++) begin
            chk("to_req", mem_req_o, 1);
            chk("to_err_quiet", err_o, 0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("to_err", err_o, 1);
        chk("to_noreq", mem_req_o, 0);
        chk("to_ready", op_ready_o, 1);
        chk("to_addr", addr_o, m_addr);
        chk("to_rdata", rdata_o, m_rdata);
        chk("to_rvalid", rdata_valid_o, 0);
        do_op(MEM_READ, 0, 0, 0, TO - 1, 'h5A);
`else
        do_op(MEM_READ, 0, 0, 0, 20, 'h5A);
`endif

        for (int n = 0; n < 80; n++) begin
            do_op(memory_op_e'(3'($urandom_range(0, 7))), int'($urandom_range(0, AMOD - 1)),
                  1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)));
        end

        // Reset while a read is pending; the late ack must be ignored.
        @(negedge clk);
        op_i = MEM_READ; op_valid_i = 1'b1; post_inc_i = 1'b1; mem_ack_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op_valid_i = 1'b0;
        chk("mid_req", mem_req_o, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_req", mem_req_o, 0);
        chk("mid_rst_addr", addr_o, 0);
        chk("mid_rst_ready", op_ready_o, 1);
        rst_n = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 'h77;
        @(posedge clk);
        @(negedge clk);
        mem_ack_i = 1'b0;
        chk("late_ack_rvalid", rdata_valid_o, 0);
        chk("late_ack_rdata", rdata_o, 0);
        chk("late_ack_req", mem_req_o, 0);
        chk("late_ack_addr", addr_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
Executes `memory_op_e` commands from the control unit against an external RAM through a req/ack handshake with arbitrary wait states. Owns the address register and supports absolute and relative address updates. Adds optional post-increment on READ/WRITE and an address-wrap indication. Sits between the control FSM and the RAM / Tiny Tapeout IO bus, generalising the fixed 9-bit address path to parametrised address and data widths.

Parameters:
- `ADDR_WIDTH`, default 9 (`control::ADDR_BUS_WIDTH`): width of the address register and memory address.
- `DATA_WIDTH`, default 8: memory data width.
- `TIMEOUT_CYCLES`, default 15: maximum number of BUS cycles without ack. Used only with `MEM_TIMEOUT_EN`; must be ≥ 1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `op_i`  in  `memory_op_e`  command.
- `op_valid_i`  in  1  command present.
- `op_ready_o`  out  1  unit idle; command accepted when `op_valid_i && op_ready_o`.
- `post_inc_i`  in  1  sampled with a READ/WRITE; address += 1 after completion.
- `addr_operand_i`  in  `ADDR_WIDTH`  operand for ABSOLUTE/REL_ADD/REL_SUB.
- `wdata_i`  in  `DATA_WIDTH`  write data, sampled at acceptance.
- `rdata_o`  out  `DATA_WIDTH`  last read data, held until the next read completes.
- `rdata_valid_o`  out  1  one-cycle pulse when `rdata_o` updates.
- `addr_o`  out  `ADDR_WIDTH`  current address register.
- `addr_wrap_o`  out  1  one-cycle pulse on address carry or borrow.
- `err_o`  out  1  one-cycle pulse on timeout; tied 0 without `MEM_TIMEOUT_EN`.
- `mem_req_o`  out  1  bus request.
- `mem_we_o`  out  1  1 = write.
- `mem_addr_o`  out  `ADDR_WIDTH`  bus address.
- `mem_wdata_o`  out  `DATA_WIDTH`  bus write data.
- `mem_rdata_i`  in  `DATA_WIDTH`  bus read data, valid with ack.
- `mem_ack_i`  in  1  transfer complete; only meaningful while `mem_req_o` = 1.

Behaviour:
- **Reset** (`rst_n` = 0 at a clock edge) forces:
  - state IDLE;
  - `addr_o`, `rdata_o`, `mem_addr_o`, `mem_wdata_o` = 0;
  - `mem_req_o`, `mem_we_o`, `rdata_valid_o`, `addr_wrap_o`, `err_o` = 0.
  - `op_ready_o` = 1 in the first cycle after reset.
  - Reset during BUS drops `mem_req_o` at that edge; a late ack is ignored.
- **FSM states:** IDLE, BUS. `op_ready_o` = (state == IDLE), combinational.
- **IDLE, accepted op:**
  - NOP: no effect.
  - ABSOLUTE: `addr <= addr_operand_i`. No wrap pulse.
  - REL_ADD: `addr <= addr + addr_operand_i` mod 2^`ADDR_WIDTH`. `addr_wrap_o` pulses next cycle if a carry-out occurs.
  - REL_SUB: `addr <= addr - addr_operand_i` mod 2^`ADDR_WIDTH`. `addr_wrap_o` pulses if a borrow occurs (`operand > addr`).
  - READ/WRITE: latch `we`, `wdata_i` and `post_inc_i`. Drive `mem_addr_o` = `addr`, `mem_req_o` = 1 from the next cycle. Go to BUS.
  - Address ops complete in 1 cycle, with ready held high.
- **BUS:**
  - `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o` are held stable until the edge at which `mem_ack_i` = 1.
  - At that edge: `mem_req_o` <= 0 and state <= IDLE.
  - On a read: `rdata_o <= mem_rdata_i` and `rdata_valid_o` pulses for 1 cycle.
  - If `post_inc` was latched: `addr <= addr + 1`. A wrap from max to 0 pulses `addr_wrap_o`.
- **Latency:** zero-wait RAM (ack in the first req cycle) gives acceptance edge N, req high in cycle N+1, `rdata_valid_o` high in cycle N+2, `op_ready_o` high in cycle N+2.
- **Back-to-back:** a new op can be accepted in the same cycle that `rdata_valid_o` is high.
- **Ignored inputs:** `op_valid_i` while busy is ignored; no queueing. Inputs other than `mem_ack_i`/`mem_rdata_i` are ignored while in BUS.
- **Undefined enum values** are treated as NOP.

Optional Feature:
- Macro `MEM_TIMEOUT_EN`.
- **Defined:** a wait counter clears on entry to BUS and increments on each BUS cycle without ack.
  - When the counter reaches `TIMEOUT_CYCLES` without ack: drop `mem_req_o`, pulse `err_o`, return to IDLE.
  - On timeout there is no post-increment, and `rdata_o`/`rdata_valid_o` are untouched.
  - If ack arrives in the expiry cycle, the ack wins and there is no error.
- **Undefined:** BUS waits indefinitely; `err_o` = 0 and no counter is synthesised.

Decomposition:
- **Package `control`:**
  - Keep `memory_op_e`.
  - Add `typedef enum logic [0:0] {MAU_IDLE, MAU_BUS} mau_state_e`.
  - Convert `ADDR_BUS_WIDTH` to package `localparam int ADDR_BUS_WIDTH = 9`.
  - Give `memory_op_e` an explicit `logic [2:0]` base type.
- **Sub-module `mem_addr_gen`:** address register plus the add/sub/increment/load datapath producing next address and wrap flag. It is parametrised by `ADDR_WIDTH` and used by `memory_access_unit`.

Test Plan:
- **Reset then ABSOLUTE:** `ADDR_WIDTH`=9, ABSOLUTE operand 0x1F0 → `addr_o`=0x1F0 next cycle, `addr_wrap_o`=0, `op_ready_o` stays 1.
- **REL_ADD wrap:** from 0x1F0, REL_ADD 0x020 → `addr_o`=0x010, `addr_wrap_o` pulses 1 cycle. Then REL_SUB 0x020 → 0x1F0, wrap pulse.
- **Zero-wait read with post-inc:** `addr`=0x1FF, READ `post_inc`=1, ack in first req cycle, `mem_rdata_i`=0xA5 → `mem_addr_o`=0x1FF; `rdata_o`=0xA5 with valid pulse at N+2; `addr_o`=0x000; wrap pulse.
- **3-wait-state write:** WRITE `wdata`=0x3C, ack after 3 req cycles → `mem_req_o`/`mem_we_o`/`mem_wdata_o` stable for 4 cycles. `op_valid_i` pulsed mid-BUS is ignored. `rdata_valid_o` never asserts.
- **Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** READ with no ack → `err_o` pulse after 4 BUS cycles, `mem_req_o` drops, `addr_o` unchanged. Repeat with ack at cycle 4 → no error, read completes.
- **Reset mid-BUS:** assert `rst_n`=0 during a pending READ → next edge `mem_req_o`=0 and `addr_o`=0. A subsequent ack is ignored and no `rdata_valid_o` pulse occurs.
